// File: rtl/uart_rom_loader_pkg.sv
// Shared widths and FSM state encoding for the UART-fed Hack ROM loader.
package uart_rom_loader_pkg;

  localparam int BYTE_W  = 8;
  localparam int COUNT_W = 16;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_SOC_RST = 4'd1,
    ST_CNT_HI  = 4'd2,
    ST_CNT_LO  = 4'd3,
    ST_W_HI    = 4'd4,
    ST_W_LO    = 4'd5,
    ST_LOAD    = 4'd6,
    ST_RELEASE = 4'd7,
    ST_SUM_HI  = 4'd8,
    ST_SUM_LO  = 4'd9,
    ST_DONE    = 4'd10
  } state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling, byte strobe
// and framing-error strobe. Start bit is re-checked half a bit after the edge.
module uart_rx_byte
  import uart_rom_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_i,
  output logic [BYTE_W-1:0] byte_o,
  output logic              byte_valid_o,
  output logic              frame_err_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic              meta_q, sync_q, prev_q;
  logic [1:0]        st_q, st_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    st_d    = st_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (st_q)
      RX_IDLE: begin
        // Arm only on a real falling edge so a low line after a framing
        // error cannot start a bogus byte.
        if (prev_q && !sync_q) begin
          st_d  = RX_START;
          cnt_d = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          bit_d = '0;
          st_d  = sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {sync_q, shift_q[BYTE_W-1:1]};
          if (bit_q == 3'd7) st_d = RX_STOP;
          else               bit_d = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          st_d    = RX_IDLE;
          valid_d = sync_q;
          ferr_d  = !sync_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      prev_q  <= 1'b1;
      st_q    <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      meta_q  <= rx_i;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign byte_o       = shift_q;
  assign byte_valid_o = valid_q;
  assign frame_err_o  = ferr_q;

endmodule

// File: rtl/uart_rom_loader.sv
// Receives a word-count-prefixed Hack program over UART and hands it to the SoC
// ROM loader port one word at a time. Optional trailing checksum: UART_ROM_LOADER_CHECKSUM_EN.
module uart_rom_loader
  import uart_rom_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int DATA_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  uart_rx,
  input  logic                  run,
  output logic                  done_loading,
  output logic                  error,
  output logic                  rom_loader_reset,
  output logic                  rom_loader_load,
  output logic [DATA_WIDTH-1:0] rom_loader_data,
  input  logic                  rom_loader_ack,
  input  logic                  rom_loader_load_received
);

  logic [BYTE_W-1:0] rx_byte;
  logic              rx_valid;
  logic              rx_ferr;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk          (clk),
    .reset        (reset),
    .rx_i         (uart_rx),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_valid),
    .frame_err_o  (rx_ferr)
  );

`ifdef UART_ROM_LOADER_CHECKSUM_EN
  localparam state_e AFTER_WORDS = ST_SUM_HI;
  logic [COUNT_W-1:0] sum_q, sum_d;
`else
  localparam state_e AFTER_WORDS = ST_DONE;
`endif

  state_e                state_q, state_d;
  logic                  error_q, error_d;
  logic [COUNT_W-1:0]    count_q, count_d;
  logic [COUNT_W-1:0]    word_cnt_q, word_cnt_d;
  logic [COUNT_W-1:0]    next_cnt;
  logic [BYTE_W-1:0]     hi_q, hi_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [2*BYTE_W-1:0]   rx_word;

  assign rx_word  = {hi_q, rx_byte};
  assign next_cnt = word_cnt_q + COUNT_W'(1);

  always_comb begin
    state_d    = state_q;
    error_d    = error_q | rx_ferr;
    count_d    = count_q;
    word_cnt_d = word_cnt_q;
    hi_d       = hi_q;
    data_d     = data_q;
`ifdef UART_ROM_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d    = ST_SOC_RST;
          error_d    = 1'b0;
          word_cnt_d = '0;
`ifdef UART_ROM_LOADER_CHECKSUM_EN
          sum_d      = '0;
`endif
        end
      end
      ST_SOC_RST: if (rom_loader_ack) state_d = ST_CNT_HI;
      ST_CNT_HI: begin
        if (rx_valid) begin
          hi_d    = rx_byte;
          state_d = ST_CNT_LO;
        end
      end
      ST_CNT_LO: begin
        if (rx_valid) begin
          count_d = rx_word;
          state_d = (rx_word == '0) ? AFTER_WORDS : ST_W_HI;
        end
      end
      ST_W_HI: begin
        if (rx_valid) begin
          hi_d    = rx_byte;
          state_d = ST_W_LO;
        end
      end
      ST_W_LO: begin
        if (rx_valid) begin
          data_d  = DATA_WIDTH'(rx_word);
          state_d = ST_LOAD;
`ifdef UART_ROM_LOADER_CHECKSUM_EN
          sum_d   = sum_q + rx_word;
`endif
        end
      end
      // The SoC handshake owns these two states; any byte arriving here is lost.
      ST_LOAD: begin
        if (rx_valid) error_d = 1'b1;
        if (rom_loader_load_received) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (rx_valid) error_d = 1'b1;
        if (!rom_loader_load_received) begin
          word_cnt_d = next_cnt;
          state_d    = (next_cnt == count_q) ? AFTER_WORDS : ST_W_HI;
        end
      end
`ifdef UART_ROM_LOADER_CHECKSUM_EN
      ST_SUM_HI: begin
        if (rx_valid) begin
          hi_d    = rx_byte;
          state_d = ST_SUM_LO;
        end
      end
      ST_SUM_LO: begin
        if (rx_valid) begin
          if (rx_word != sum_q) error_d = 1'b1;
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE: if (!run) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (!run && state_q != ST_IDLE && state_q != ST_DONE) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      error_q    <= 1'b0;
      count_q    <= '0;
      word_cnt_q <= '0;
      hi_q       <= '0;
      data_q     <= '0;
`ifdef UART_ROM_LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      error_q    <= error_d;
      count_q    <= count_d;
      word_cnt_q <= word_cnt_d;
      hi_q       <= hi_d;
      data_q     <= data_d;
`ifdef UART_ROM_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign rom_loader_reset = (state_q == ST_SOC_RST);
  assign rom_loader_load  = (state_q == ST_LOAD);
  assign rom_loader_data  = rom_loader_load ? data_q : '0;
  assign done_loading     = (state_q == ST_DONE) && run;
  assign error            = error_q;

endmodule

// File: tb/tb_uart_rom_loader.sv
// Directed bench for uart_rom_loader with a small SoC loader-port model.
module tb_uart_rom_loader;
  import uart_rom_loader_pkg::*;

  localparam int C = 4;
`ifdef UART_ROM_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, uart_rx, run;
  logic        done_loading, error, rom_loader_reset, rom_loader_load;
  logic [15:0] rom_loader_data;
  logic        rom_loader_ack, rom_loader_load_received;

  uart_rom_loader #(.CLKS_PER_BIT(C), .DATA_WIDTH(16)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .uart_rx                 (uart_rx),
    .run                     (run),
    .done_loading            (done_loading),
    .error                   (error),
    .rom_loader_reset        (rom_loader_reset),
    .rom_loader_load         (rom_loader_load),
    .rom_loader_data         (rom_loader_data),
    .rom_loader_ack          (rom_loader_ack),
    .rom_loader_load_received(rom_loader_load_received)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          strobes = 0;
  int          pulses = 0;
  logic        soc_hold = 1'b0;
  logic [15:0] got[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // SoC model: ack 3 cycles into loader-reset, latch each word 2 cycles after load.
  initial begin
    int ack_cnt, load_cnt;
    ack_cnt = 0;
    load_cnt = 0;
    rom_loader_ack = 1'b0;
    rom_loader_load_received = 1'b0;
    forever begin
      @(negedge clk);
      if (rom_loader_reset) begin
        if (ack_cnt < 3) ack_cnt++;
        rom_loader_ack = (ack_cnt >= 3);
      end else begin
        ack_cnt = 0;
        rom_loader_ack = 1'b0;
      end
      if (rom_loader_load) begin
        load_cnt++;
        if (load_cnt == 1) pulses++;
        if (load_cnt == 2 && !soc_hold) begin
          got.push_back(rom_loader_data);
          rom_loader_load_received = 1'b1;
        end
      end else begin
        load_cnt = 0;
        rom_loader_load_received = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (dut.rx_valid) strobes++;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    uart_rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (C) @(negedge clk);
    end
    uart_rx = stop_ok;
    repeat (C) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * C) @(negedge clk);
  endtask

  task automatic run_session(input logic [15:0] n, input logic [15:0] w0, input logic [15:0] w1,
                             input int bad_idx, input logic [15:0] sum_adj);
    logic [7:0]  bytes[$];
    logic [15:0] sum;
    run = 1'b0;
    repeat (3) @(negedge clk);
    got.delete();
    pulses = 0;
    run = 1'b1;
    repeat (8) @(negedge clk);
    sum = 16'h0000;
    bytes.push_back(n[15:8]);
    bytes.push_back(n[7:0]);
    if (n >= 16'd1) begin bytes.push_back(w0[15:8]); bytes.push_back(w0[7:0]); sum = sum + w0; end
    if (n >= 16'd2) begin bytes.push_back(w1[15:8]); bytes.push_back(w1[7:0]); sum = sum + w1; end
    sum = sum + sum_adj;
    if (CSUM_EN) begin bytes.push_back(sum[15:8]); bytes.push_back(sum[7:0]); end
    foreach (bytes[i]) begin
      send_byte(bytes[i], i != bad_idx);
      if (i == bad_idx) send_byte(bytes[i], 1'b1);
    end
    for (int k = 0; k < 40 && !done_loading; k++) @(negedge clk);
  endtask

  typedef struct {
    logic [15:0] n;
    logic [15:0] w0;
    logic [15:0] w1;
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int s0, cyc;
    vecs[0] = '{16'd2, 16'h1234, 16'hABCD, 1'b1, 1'b0};
    vecs[1] = '{16'd0, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'd1, 16'hFFFF, 16'h0000, 1'b1, 1'b0};
    vecs[3] = '{16'd2, 16'h0000, 16'h8001, 1'b1, 1'b0};

    reset = 1'b1;
    run = 1'b0;
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_done", done_loading, 0);
    check("rst_error", error, 0);
    check("rst_soc_reset", rom_loader_reset, 0);
    check("rst_load", rom_loader_load, 0);
    check("rst_data", rom_loader_data, 0);

    // One-cycle low glitch on an idle line must not produce a byte.
    s0 = strobes;
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_no_strobe", strobes - s0, 0);

    // Byte strobe latency from start-bit falling edge: 2 + 9.5*C, +/-1.
    cyc = 0;
    fork
      send_byte(8'hA5, 1'b1);
      begin
        while (!dut.rx_valid && cyc < 100) begin
          @(negedge clk);
          cyc++;
        end
        check("rx_latency_window", (cyc >= 39 && cyc <= 41), 1);
        check("rx_byte_value", dut.rx_byte, 8'hA5);
      end
    join

    for (int v = 0; v < 4; v++) begin
      run_session(vecs[v].n, vecs[v].w0, vecs[v].w1, -1, 16'h0000);
      check($sformatf("vec%0d_pulses", v), pulses, vecs[v].n);
      for (int k = 0; k < int'(vecs[v].n); k++)
        check($sformatf("vec%0d_word%0d", v, k), (got.size() > k) ? got[k] : 16'hDEAD,
              (k == 0) ? vecs[v].w0 : vecs[v].w1);
      check($sformatf("vec%0d_done", v), done_loading, vecs[v].exp_done);
      check($sformatf("vec%0d_error", v), error, vecs[v].exp_err);
    end

    // Framing error on byte 0x34: dropped, error set, resent byte completes the load.
    run_session(16'd2, 16'h1234, 16'hABCD, 3, 16'h0000);
    check("ferr_pulses", pulses, 2);
    check("ferr_word0", (got.size() > 0) ? got[0] : 16'hDEAD, 16'h1234);
    check("ferr_word1", (got.size() > 1) ? got[1] : 16'hDEAD, 16'hABCD);
    check("ferr_done", done_loading, 1);
    check("ferr_error", error, 1);

    // Abort during LOAD, then restart.
    run = 1'b0;
    repeat (3) @(negedge clk);
    soc_hold = 1'b1;
    run = 1'b1;
    repeat (8) @(negedge clk);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    for (int k = 0; k < 20 && !rom_loader_load; k++) @(negedge clk);
    check("abort_load_up", rom_loader_load, 1);
    check("abort_load_data", rom_loader_data, 16'h1234);
    send_byte(8'h99, 1'b1);
    check("abort_byte_in_load_error", error, 1);
    check("abort_load_still_held", rom_loader_load, 1);
    run = 1'b0;
    @(negedge clk);
    check("abort_load_drop", rom_loader_load, 0);
    check("abort_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
    check("abort_error_sticky", error, 1);
    run = 1'b1;
    @(negedge clk);
    check("restart_state", 32'(dut.state_q), 32'(ST_SOC_RST));
    check("restart_error_clr", error, 0);
    check("restart_soc_reset", rom_loader_reset, 1);
    soc_hold = 1'b0;
    run = 1'b0;
    repeat (3) @(negedge clk);

`ifdef UART_ROM_LOADER_CHECKSUM_EN
    run_session(16'd2, 16'h0001, 16'hFFFF, -1, 16'h0000);
    check("csum_ok_done", done_loading, 1);
    check("csum_ok_error", error, 0);
    run_session(16'd2, 16'h0001, 16'hFFFF, -1, 16'h0001);
    check("csum_bad_done", done_loading, 1);
    check("csum_bad_error", error, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
